// File: rtl/auth_request_arbiter.sv
// Arbitrates PD/DEBUG pending authentication slots onto a single valid/ready request channel,
// then pulses the matching erase line once the controller finishes or the request times out.
module auth_request_arbiter #(
    parameter int unsigned SLOTS       = 4,
    parameter int unsigned CODE_W      = 2,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SLOTS*CODE_W-1:0]   pending_auth_request_PD,
    input  logic [SLOTS*CODE_W-1:0]   pending_auth_request_DEBUG,
    input  logic                      auth_req_ready,
    input  logic                      auth_done,
    output logic                      auth_req_valid,
    output logic                      auth_req_src,
    output logic [$clog2(SLOTS)-1:0]  auth_req_slot,
    output logic [CODE_W-1:0]         auth_req_code,
    output logic                      pending_auth_request_PD_erase,
    output logic                      pending_auth_request_DEBUG_erase,
    output logic [$clog2(SLOTS)-1:0]  erase_slot,
    output logic                      timeout_err
);

    localparam int unsigned SLOT_W = $clog2(SLOTS);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitDone, StErase, StGuard} state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic                src_q, src_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                pd_erase_q, pd_erase_d;
    logic                dbg_erase_q, dbg_erase_d;
    logic [SLOT_W-1:0]   erase_slot_q, erase_slot_d;
    logic                timeout_q, timeout_d;
    logic                last_src_q, last_src_d;

    logic                pd_hit, dbg_hit, pick_dbg;
    logic [SLOT_W-1:0]   pd_slot, dbg_slot;
    logic [CODE_W-1:0]   pd_code, dbg_code;

    // Walk from the top slot down so the lowest non-empty slot wins.
    always_comb begin
        pd_hit   = 1'b0;
        pd_slot  = '0;
        pd_code  = '0;
        dbg_hit  = 1'b0;
        dbg_slot = '0;
        dbg_code = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (pending_auth_request_PD[CODE_W*i +: CODE_W] != '0) begin
                pd_hit  = 1'b1;
                pd_slot = i[SLOT_W-1:0];
                pd_code = pending_auth_request_PD[CODE_W*i +: CODE_W];
            end
            if (pending_auth_request_DEBUG[CODE_W*i +: CODE_W] != '0) begin
                dbg_hit  = 1'b1;
                dbg_slot = i[SLOT_W-1:0];
                dbg_code = pending_auth_request_DEBUG[CODE_W*i +: CODE_W];
            end
        end
        pick_dbg = dbg_hit && (!pd_hit || !last_src_q);
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = 1'b0;
        src_d        = src_q;
        slot_d       = slot_q;
        code_d       = code_q;
        cnt_d        = cnt_q;
        pd_erase_d   = 1'b0;
        dbg_erase_d  = 1'b0;
        erase_slot_d = erase_slot_q;
        timeout_d    = 1'b0;
        last_src_d   = last_src_q;
        unique case (state_q)
            StIdle: begin
                if (pd_hit || dbg_hit) begin
                    src_d   = pick_dbg;
                    slot_d  = pick_dbg ? dbg_slot : pd_slot;
                    code_d  = pick_dbg ? dbg_code : pd_code;
                    valid_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                valid_d = 1'b1;
                if (valid_q && auth_req_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (cnt_q != TO_W'(TIMEOUT_CYC)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (auth_done) begin
                    state_d = StErase;
                end else if (cnt_q == TO_W'(TIMEOUT_CYC)) begin
                    timeout_d = 1'b1;
                    state_d   = StErase;
                end
            end
            StErase: begin
                pd_erase_d   = !src_q;
                dbg_erase_d  = src_q;
                erase_slot_d = slot_q;
                last_src_d   = src_q;
                state_d      = StGuard;
            end
            StGuard: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            valid_q      <= 1'b0;
            src_q        <= 1'b0;
            slot_q       <= '0;
            code_q       <= '0;
            cnt_q        <= '0;
            pd_erase_q   <= 1'b0;
            dbg_erase_q  <= 1'b0;
            erase_slot_q <= '0;
            timeout_q    <= 1'b0;
            last_src_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            src_q        <= src_d;
            slot_q       <= slot_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
            pd_erase_q   <= pd_erase_d;
            dbg_erase_q  <= dbg_erase_d;
            erase_slot_q <= erase_slot_d;
            timeout_q    <= timeout_d;
            last_src_q   <= last_src_d;
        end
    end

    assign auth_req_valid                   = valid_q;
    assign auth_req_src                     = src_q;
    assign auth_req_slot                    = slot_q;
    assign auth_req_code                    = code_q;
    assign pending_auth_request_PD_erase    = pd_erase_q;
    assign pending_auth_request_DEBUG_erase = dbg_erase_q;
    assign erase_slot                       = erase_slot_q;
    assign timeout_err                      = timeout_q;

endmodule

// File: tb/tb_auth_request_arbiter.sv
// Directed bench for auth_request_arbiter: arbitration, handshake hold, timeout and reset cases.
module tb_auth_request_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pd, dbg;
    logic       ready, done;
    logic       valid, src;
    logic [1:0] slot, code;
    logic       pd_erase, dbg_erase;
    logic [1:0] erase_slot;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;

    auth_request_arbiter dut (
        .clk                              (clk),
        .reset                            (reset),
        .pending_auth_request_PD          (pd),
        .pending_auth_request_DEBUG       (dbg),
        .auth_req_ready                   (ready),
        .auth_done                        (done),
        .auth_req_valid                   (valid),
        .auth_req_src                     (src),
        .auth_req_slot                    (slot),
        .auth_req_code                    (code),
        .pending_auth_request_PD_erase    (pd_erase),
        .pending_auth_request_DEBUG_erase (dbg_erase),
        .erase_slot                       (erase_slot),
        .timeout_err                      (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {valid, src, slot, code}
    task automatic check_req(input string tag, input logic s, input logic [1:0] sl,
                             input logic [1:0] c);
        check_eq(tag, {26'd0, valid, src, slot, code}, {26'd0, 1'b1, s, sl, c});
    endtask

    // From an ISSUE cycle with ready=1: transfer, done pulse, erase check, back to IDLE.
    task automatic finish_req(input string tag, input logic s, input logic [1:0] sl,
                              input logic clr_pd, input logic clr_dbg);
        step();
        check_eq({tag, "_xfer_valid"}, {31'd0, valid}, 32'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        check_eq({tag, "_erase_early"}, {29'd0, pd_erase, dbg_erase, timeout_err}, 32'd0);
        step();
        check_eq({tag, "_erase"}, {28'd0, pd_erase, dbg_erase, erase_slot},
                 {28'd0, ~s, s, sl});
        if (clr_pd) pd = 8'h00;
        if (clr_dbg) dbg = 8'h00;
        step();
        check_eq({tag, "_erase_end"}, {30'd0, pd_erase, dbg_erase}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int to_seen;
        reset = 1'b0;
        pd    = 8'h00;
        dbg   = 8'h00;
        ready = 1'b1;
        done  = 1'b0;
        step();
        step();
        check_eq("reset_outputs", {22'd0, valid, src, slot, code, pd_erase, dbg_erase,
                 erase_slot, timeout_err}, 32'd0);

        // T1: DEBUG only, slot0 code2
        dbg   = 8'b00_10_01_10;
        reset = 1'b1;
        step();
        check_req("t1_req", 1'b1, 2'd0, 2'd2);
        finish_req("t1", 1'b1, 2'd0, 1'b0, 1'b1);

        // T2: after reset both pending, PD wins first, then DEBUG
        reset = 1'b0;
        step();
        pd    = 8'b00_00_11_00;
        dbg   = 8'h02;
        reset = 1'b1;
        step();
        check_req("t2_req_pd", 1'b0, 2'd1, 2'd3);
        finish_req("t2_pd", 1'b0, 2'd1, 1'b1, 1'b0);
        step();
        check_req("t2_req_dbg", 1'b1, 2'd0, 2'd2);
        finish_req("t2_dbg", 1'b1, 2'd0, 1'b0, 1'b1);

        // T3: ready held low 5 cycles, input change ignored
        pd    = 8'h01;
        ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check_req("t3_hold", 1'b0, 2'd0, 2'd1);
            pd = 8'h30;
            step();
        end
        check_req("t3_hold6", 1'b0, 2'd0, 2'd1);
        ready = 1'b1;
        finish_req("t3", 1'b0, 2'd0, 1'b1, 1'b0);

        // T4: no done, timeout after counter reaches 255
        dbg = 8'h04;
        step();
        check_req("t4_req", 1'b1, 2'd1, 2'd1);
        step();
        to_seen = 0;
        repeat (255) begin
            if (timeout_err) to_seen++;
            step();
        end
        check_eq("t4_no_early_to", to_seen + {31'd0, timeout_err}, 32'd0);
        step();
        check_eq("t4_timeout", {29'd0, timeout_err, pd_erase, dbg_erase}, 32'b100);
        step();
        check_eq("t4_erase", {28'd0, timeout_err, pd_erase, dbg_erase, erase_slot[0]},
                 32'b0011);
        check_eq("t4_guard_valid", {31'd0, valid}, 32'd0);
        step();
        check_eq("t4_idle_valid", {31'd0, valid}, 32'd0);
        dbg = 8'h00;
        step();
        check_eq("t4_quiet", {30'd0, valid, timeout_err}, 32'd0);

        // T6: done coincident with counter==255
        pd = 8'b10_00_00_00;
        step();
        check_req("t6_req", 1'b0, 2'd3, 2'd2);
        step();
        repeat (255) step();
        done = 1'b1;
        step();
        done = 1'b0;
        check_eq("t6_no_timeout", {31'd0, timeout_err}, 32'd0);
        step();
        check_eq("t6_erase", {28'd0, pd_erase, dbg_erase, erase_slot}, 32'b1011);
        pd = 8'h00;
        step();

        // T5: reset during WAIT_DONE
        dbg = 8'h01;
        step();
        check_req("t5_req", 1'b1, 2'd0, 2'd1);
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        check_eq("t5_reset_async", {22'd0, valid, src, slot, code, pd_erase, dbg_erase,
                 erase_slot, timeout_err}, 32'd0);
        step();
        check_eq("t5_reset_hold", {29'd0, pd_erase, dbg_erase, timeout_err}, 32'd0);
        reset = 1'b1;
        step();
        check_req("t5_reissue", 1'b1, 2'd0, 2'd1);
        finish_req("t5", 1'b1, 2'd0, 1'b0, 1'b1);

        // T7: round robin with both sources continuously pending
        pd  = 8'h02;
        dbg = 8'h08;
        step();
        check_req("t7_req_pd", 1'b0, 2'd0, 2'd2);
        finish_req("t7_pd", 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        check_req("t7_req_dbg", 1'b1, 2'd1, 2'd2);
        finish_req("t7_dbg", 1'b1, 2'd1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
